// File: rtl/sram_gpu_model.sv
// sram_gpu_model
// Behavioural model of a single-port synchronous GPU SRAM macro holding
// 2^AW words of DW bits, with a registered (1-cycle) read port and a
// synchronous write port that also writes through to the output register.
//
// Ports:
//   CLK   - clock; every array access happens on its rising edge
//   RSTN  - asynchronous active-low reset; clears Q only, never the array
//   CEN   - chip enable, active-low (1 = no access)
//   WEN   - write enable, active-low (0 = write, 1 = read) when CEN = 0
//   A     - word address, the full 0 .. 2^AW-1 range is valid
//   D     - write data
//   EMA   - extra margin adjust; timing trim with no functional effect
//   RETN  - retention, active-low; forces Q to 0 and blocks all accesses
//   Q     - registered read data
module sram_gpu_model #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CEN,
  input  logic          WEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  input  logic [2:0]    EMA,
  input  logic          RETN,
  output logic [DW-1:0] Q
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] q_r;

  // Reset and retention both clear Q asynchronously and both block access,
  // so they share one active-low clear for the output register.
  logic clr_n_s;
  logic ctrl_unknown_s;
  logic a_unknown_s;
  logic corrupt_s;
  logic ema_unused_s;

  assign clr_n_s = RSTN & RETN;

  // The === 1'bx tests only fire in a four-state simulator; in hardware
  // they fold to constant false and the model reduces to a plain SRAM.
  assign ctrl_unknown_s = ((^{CEN, WEN, A}) === 1'bx);
  assign a_unknown_s    = ((^A) === 1'bx);

  // A possibly-enabled, possibly-write edge with bad controls poisons the
  // array; a known deselect or a known read leaves the array untouched.
  assign corrupt_s = ctrl_unknown_s && (CEN !== 1'b1) && (WEN !== 1'b1);

  // EMA only trims timing in silicon; it is consumed here so it stays wired.
  assign ema_unused_s = ^EMA;

  // Output register: async clear, read data or write-through on access,
  // hold otherwise (including the idle cycles after retention exit).
  always_ff @(posedge CLK or negedge clr_n_s) begin
    if (!clr_n_s) begin
      q_r <= {DW{1'b0}};
    end else if (ctrl_unknown_s) begin
      q_r <= {DW{1'bx}};
    end else if (!CEN) begin
      if (!WEN) begin
        q_r <= D;
      end else begin
        q_r <= mem_r[A];
      end
    end else begin
      q_r <= q_r;
    end
  end

  // Storage array: no reset by design, so contents survive RSTN and RETN.
  always_ff @(posedge CLK) begin
    if (clr_n_s) begin
      if (corrupt_s) begin
        if (a_unknown_s) begin
          mem_r <= '{default: {DW{1'bx}}};
        end else begin
          mem_r[A] <= {DW{1'bx}};
        end
      end else if (!ctrl_unknown_s && !CEN && !WEN) begin
        mem_r[A] <= D;
      end
    end
  end

  assign Q = q_r;

endmodule

// File: tb/tb_sram_gpu_model.sv
// Directed self-checking bench for sram_gpu_model. Two instances form a
// paired bank (shared A/D, separate write enables); the low instance carries
// the single-macro tests, both together carry the 16-bit paired-bank test.
module tb_sram_gpu_model;

  logic        clk;
  logic        rstn;
  logic        cen;
  logic        wen;
  logic        sel;
  logic        retn;
  logic [10:0] a;
  logic [7:0]  d;
  logic [2:0]  ema;
  logic        wen_lo;
  logic        wen_hi;
  logic [7:0]  q_lo;
  logic [7:0]  q_hi;

  int checks;
  int errors;

  assign wen_lo = wen | sel;
  assign wen_hi = wen | ~sel;

  sram_gpu_model #(.DW(8), .AW(11)) u_lo (
    .CLK  (clk),
    .RSTN (rstn),
    .CEN  (cen),
    .WEN  (wen_lo),
    .A    (a),
    .D    (d),
    .EMA  (ema),
    .RETN (retn),
    .Q    (q_lo)
  );

  sram_gpu_model #(.DW(8), .AW(11)) u_hi (
    .CLK  (clk),
    .RSTN (rstn),
    .CEN  (cen),
    .WEN  (wen_hi),
    .A    (a),
    .D    (d),
    .EMA  (ema),
    .RETN (retn),
    .Q    (q_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One active edge, then return to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [10:0] addr, input logic [7:0] data);
    cen = 1'b0; wen = 1'b0; a = addr; d = data;
    step();
  endtask

  task automatic do_read(input logic [10:0] addr);
    cen = 1'b0; wen = 1'b1; a = addr; d = 8'h00;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0; cen = 1'b1; wen = 1'b1; sel = 1'b0; retn = 1'b1;
    a = 11'h000; d = 8'h00; ema = 3'd0;

    #1;
    check("reset_q_lo", {8'h00, q_lo}, 16'h0000);
    check("reset_q_hi", {8'h00, q_hi}, 16'h0000);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Write/read at both address extremes, write-through visible on Q.
    do_write(11'h000, 8'h3C);
    check("wr_thru_000", {8'h00, q_lo}, 16'h003C);
    ema = 3'd7;
    do_write(11'h7FF, 8'hC3);
    check("wr_thru_7ff", {8'h00, q_lo}, 16'h00C3);
    do_read(11'h000);
    check("rd_000", {8'h00, q_lo}, 16'h003C);
    ema = 3'd2;
    do_read(11'h7FF);
    check("rd_7ff", {8'h00, q_lo}, 16'h00C3);

    // Async reset mid-cycle, then a write edge during reset must be dropped.
    do_write(11'h020, 8'hA5);
    do_read(11'h020);
    check("rd_a5", {8'h00, q_lo}, 16'h00A5);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_async", {8'h00, q_lo}, 16'h0000);
    cen = 1'b0; wen = 1'b0; a = 11'h020; d = 8'h5A;
    step();
    check("rst_edge_q", {8'h00, q_lo}, 16'h0000);
    rstn = 1'b1;
    do_read(11'h020);
    check("rst_no_write", {8'h00, q_lo}, 16'h00A5);

    // Chip disable holds Q and blocks the would-be write.
    do_write(11'h040, 8'h55);
    do_read(11'h040);
    check("cd_rd", {8'h00, q_lo}, 16'h0055);
    for (int i = 0; i < 3; i++) begin
      cen = 1'b1; wen = 1'b0; a = 11'h040; d = 8'hFF;
      step();
      check("cd_hold", {8'h00, q_lo}, 16'h0055);
    end
    do_read(11'h040);
    check("cd_rd_after", {8'h00, q_lo}, 16'h0055);

    // Back-to-back accesses with no bubbles.
    do_write(11'd5, 8'h11);
    check("b2b_w5", {8'h00, q_lo}, 16'h0011);
    do_read(11'd5);
    check("b2b_r5", {8'h00, q_lo}, 16'h0011);
    do_write(11'd6, 8'h22);
    check("b2b_w6", {8'h00, q_lo}, 16'h0022);
    do_read(11'd6);
    check("b2b_r6", {8'h00, q_lo}, 16'h0022);
    do_read(11'd5);
    check("b2b_r5_again", {8'h00, q_lo}, 16'h0011);

    // Retention: Q forced low at once, no writes, contents kept.
    do_write(11'd10, 8'h9A);
    check("ret_wr", {8'h00, q_lo}, 16'h009A);
    #2;
    retn = 1'b0;
    #1;
    check("ret_async", {8'h00, q_lo}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      cen = 1'b0; wen = 1'b0; a = 11'd10; d = 8'h00;
      step();
      check("ret_hold", {8'h00, q_lo}, 16'h0000);
    end
    retn = 1'b1; cen = 1'b1; wen = 1'b1;
    step();
    check("ret_exit_idle", {8'h00, q_lo}, 16'h0000);
    do_read(11'd10);
    check("ret_kept", {8'h00, q_lo}, 16'h009A);

    // Paired bank: low/high halves written separately via sel.
    sel = 1'b0;
    do_write(11'd3, 8'hAB);
    sel = 1'b1;
    do_write(11'd3, 8'hCD);
    check("pair_wr_hi", {8'h00, q_hi}, 16'h00CD);
    sel = 1'b0;
    do_read(11'd3);
    check("pair_rd", {q_hi, q_lo}, 16'hCDAB);
    cen = 1'b1; wen = 1'b1;
    step();
    check("pair_hold", {q_hi, q_lo}, 16'hCDAB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_gpu_model.md
Name: sram_gpu_model

Overview:
- Behavioural model of a single-port, synchronous GPU SRAM macro: 2^AW words of DW bits.
- Provides a registered read port with one-cycle latency and a synchronous write port.
- Its port set follows the foundry single-port macro convention, with an added asynchronous reset.
- The GPU memory wrapper instantiates two of these per bank: they share address and data, each has its own write enable, and together they form a 2*DW-bit read word.

Parameters:
- DW, 8, data word width in bits.
- AW, 11, address width; depth = 2^AW words (2048 by default).

Ports:
- CLK  input  1  clock; all array accesses occur on the rising edge.
- RSTN  input  1  asynchronous active-low reset; clears the output register only.
- CEN  input  1  chip enable, active-low; 1 means no access.
- WEN  input  1  write enable, active-low; 0 means write, 1 means read (only when CEN=0).
- A  input  AW  word address.
- D  input  DW  write data.
- EMA  input  3  extra margin adjust; timing trim, functionally ignored.
- RETN  input  1  retention control, active-low; 0 puts the macro into retention.
- Q  output  DW  registered read data.

Behaviour:
- Storage: array of 2^AW words x DW bits.
  - Contents are undefined (X) at power-up.
  - Contents are never modified by RSTN or RETN.
- Reset:
  - RSTN=0 forces Q to 0 immediately, independent of CLK.
  - While RSTN=0, rising edges perform no read and no write.
  - Accesses resume on the first rising edge after RSTN returns to 1.
- Rising edge of CLK, with RSTN=1 and RETN=1:
  - CEN=1: no access; Q holds its previous value; array unchanged.
  - CEN=0, WEN=1 (read): Q <= mem[A]. Data is visible after the edge (1-cycle latency) and held until the next access.
  - CEN=0, WEN=0 (write): mem[A] <= D, and Q <= D (write-through).
- Retention (RETN=0):
  - Q is forced to 0 asynchronously while RETN=0.
  - Rising edges perform no access; array contents are retained.
  - After RETN returns to 1, Q stays 0 until the next read or write.
- EMA: any value is accepted; it has no functional effect.
- Read-after-write to the same address on the next edge returns the newly written data.
- Back-to-back accesses are supported every cycle with no bubbles.
- The full address range 0 .. 2^AW-1 is valid and there is no wrap logic; A always indexes in range.
- X or Z on CEN, WEN or A during an active edge (RSTN=1, RETN=1):
  - The model drives Q to all-X.
  - If WEN is not a known 1 and CEN is not a known 1, it also corrupts mem[A] (or the whole array if A is unknown) to X.
  - Known-good stimulus never hits this case.
- Inputs are sampled at the rising edge. Hold time is satisfied by upstream delay; the model imposes no timing checks.

Test Plan:
- Reset: drive RSTN=0 mid-cycle after a read that left Q=8'hA5 -> Q becomes 8'h00 immediately. An edge with CEN=0/WEN=0 during reset leaves the target word unchanged when read back after RSTN=1.
- Write/read: write D=8'h3C to A=11'h000 and D=8'hC3 to A=11'h7FF, then read both -> Q=8'h3C, then 8'hC3, one cycle after each read edge. Each write edge also shows its D on Q.
- Chip disable: after a read returning 8'h55, hold CEN=1 with WEN=0, A=same, D=8'hFF for 3 cycles -> Q stays 8'h55 and a later read returns 8'h55.
- Back-to-back: write A=5 with 8'h11, next cycle read A=5, next cycle write A=6 with 8'h22, next cycle read A=6 -> Q sequence 8'h11, 8'h11, 8'h22, 8'h22.
- Retention: write A=10 with 8'h9A, then RETN=0 for 4 cycles with CEN=0/WEN=0/D=8'h00 -> Q=0 and no write. After RETN=1, a read of A=10 -> 8'h9A.
- Paired banks: two instances share A and D, with WEN_low = wen|sel and WEN_high = wen|~sel. Write 8'hAB with sel=0 and 8'hCD with sel=1 at A=3, then read -> combined {high,low} = 16'hCDAB.
